truth_table_sequencer: RTL and testbench

// Exhaustive self-check controller for small combinational circuits (3-input f(x,y,z) blocks).
// On start, steps dut_in through every input pattern 0 .. 2^N_IN-1 and waits SETTLE cycles per pattern.

---
 rtl/truth_table_sequencer.sv | 133 +++++++++++++
 tb/tb_truth_table_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sequencer.sv
// Purpose: exhaustive truth-table checker for one small combinational DUT.
// Latency: a full run takes 2^N_IN*(SETTLE+1) cycles from the cycle after start is sampled.
// Backpressure: none; start is accepted only in IDLE/DONE and ignored while busy.
//
// Ports:
//   i_clk         rising-edge clock
//   i_rst         synchronous reset, active-high (abandons any run, no partial report)
//   i_start       begin a run; sampled in IDLE or DONE only
//   i_dut_out     combinational output of the DUT under test
//   o_dut_in      pattern driven to the DUT as {x,y,z}, MSB = x
//   o_busy        high while a run is in progress (SETTLE/CHECK)
//   o_done        level, high in DONE until the next start or reset
//   o_pass        valid while o_done: 1 iff o_err_count == 0
//   o_err_count   number of mismatching patterns, 0 .. 2^N_IN (never wraps)
//   o_fail_valid  high once any mismatch has been recorded in the current run
//   o_first_fail  pattern index of the first mismatch; 0 while o_fail_valid == 0
module truth_table_sequencer #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1,
  parameter logic [(1<<N_IN)-1:0] EXPECT = 8'b1011_1000
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic            i_dut_out,
  output logic [N_IN-1:0] o_dut_in,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_pass,
  output logic [N_IN:0]   o_err_count,
  output logic            o_fail_valid,
  output logic [N_IN-1:0] o_first_fail
);

  localparam int EW = N_IN + 1;
  // Settle counter holds SETTLE-1 down to 0; keep at least one bit for SETTLE==1.
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   SETTLE_LOAD = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] LAST_PAT    = {N_IN{1'b1}};

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_CHECK  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]      r_state;
  logic [CW-1:0]   r_settle_cnt;
  logic [N_IN-1:0] r_dut_in;
  logic            r_busy;
  logic            r_done;
  logic            r_pass;
  logic [N_IN:0]   r_err_count;
  logic            r_fail_valid;
  logic [N_IN-1:0] r_first_fail;

  logic            w_mismatch;
  logic [N_IN:0]   w_err_next;
  logic            w_last;

  assign w_mismatch = (i_dut_out != EXPECT[r_dut_in]);
  // Only consumed in CHECK, so the final verdict includes the last pattern's mismatch.
  assign w_err_next = r_err_count + EW'(w_mismatch);
  assign w_last     = (r_dut_in == LAST_PAT);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_settle_cnt <= '0;
      r_dut_in     <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err_count  <= '0;
      r_fail_valid <= 1'b0;
      r_first_fail <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          // A restart from DONE clears the previous report before the new run.
          if (i_start) begin
            r_state      <= S_SETTLE;
            r_settle_cnt <= SETTLE_LOAD;
            r_dut_in     <= '0;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err_count  <= '0;
            r_fail_valid <= 1'b0;
            r_first_fail <= '0;
          end
        end

        S_SETTLE: begin
          if (r_settle_cnt == '0) begin
            r_state <= S_CHECK;
          end else begin
            r_settle_cnt <= r_settle_cnt - CW'(1);
          end
        end

        S_CHECK: begin
          r_err_count <= w_err_next;
          if (w_mismatch && !r_fail_valid) begin
            r_fail_valid <= 1'b1;
            r_first_fail <= r_dut_in;
          end
          if (w_last) begin
            // dut_in stays on the last pattern while the report is held.
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == '0);
          end else begin
            r_state      <= S_SETTLE;
            r_settle_cnt <= SETTLE_LOAD;
            r_dut_in     <= r_dut_in + N_IN'(1);
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_dut_in     = r_dut_in;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_pass       = r_pass;
  assign o_err_count  = r_err_count;
  assign o_fail_valid = r_fail_valid;
  assign o_first_fail = r_first_fail;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Purpose: self-checking bench for truth_table_sequencer (SETTLE=1 and SETTLE=3 instances).
// Latency: runs are timed against 2^N_IN*(SETTLE+1) cycles from the start edge.
// Backpressure: none; start is also re-pulsed mid-run to confirm it is ignored.
module tb_truth_table_sequencer;

  localparam int N_IN = 3;
  localparam int NPAT = 1 << N_IN;
  localparam logic [NPAT-1:0] EXP_TT = 8'b1011_1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start0, start1;
  logic [NPAT-1:0] truth0, truth1;

  logic [N_IN-1:0] dut_in0, dut_in1, first0, first1;
  logic [N_IN:0]   err0, err1;
  logic busy0, busy1, done0, done1, pass0, pass1, fv0, fv1;
  logic dut_out0, dut_out1;

  // Combinational "circuits under test": each is just a truth table lookup.
  assign dut_out0 = truth0[dut_in0];
  assign dut_out1 = truth1[dut_in1];

  truth_table_sequencer #(.N_IN(N_IN), .SETTLE(1), .EXPECT(EXP_TT)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start0), .i_dut_out(dut_out0),
    .o_dut_in(dut_in0), .o_busy(busy0), .o_done(done0), .o_pass(pass0),
    .o_err_count(err0), .o_fail_valid(fv0), .o_first_fail(first0)
  );

  truth_table_sequencer #(.N_IN(N_IN), .SETTLE(3), .EXPECT(EXP_TT)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start1), .i_dut_out(dut_out1),
    .o_dut_in(dut_in1), .o_busy(busy1), .o_done(done1), .o_pass(pass1),
    .o_err_count(err1), .o_fail_valid(fv1), .o_first_fail(first1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // f = (x|y)&(~y|z) evaluated per pattern, x = MSB.
  function automatic logic [NPAT-1:0] golden_tt();
    logic [NPAT-1:0] tt;
    logic x, y, z;
    tt = '0;
    for (int i = 0; i < NPAT; i++) begin
      x = ((i >> 2) & 1) != 0;
      y = ((i >> 1) & 1) != 0;
      z = (i & 1) != 0;
      tt[i] = (x | y) & (~y | z);
    end
    return tt;
  endfunction

  // Reference report: count and first index of entries differing from the expected table.
  function automatic int ref_errs(input logic [NPAT-1:0] tt);
    int n = 0;
    for (int i = 0; i < NPAT; i++) if (tt[i] != EXP_TT[i]) n++;
    return n;
  endfunction

  function automatic int ref_first(input logic [NPAT-1:0] tt);
    for (int i = 0; i < NPAT; i++) if (tt[i] != EXP_TT[i]) return i;
    return 0;
  endfunction

  function automatic logic [31:0] o_busy(input int sel);  return sel ? busy1 : busy0;     endfunction
  function automatic logic [31:0] o_done(input int sel);  return sel ? done1 : done0;     endfunction
  function automatic logic [31:0] o_pass(input int sel);  return sel ? pass1 : pass0;     endfunction
  function automatic logic [31:0] o_err(input int sel);   return sel ? err1 : err0;       endfunction
  function automatic logic [31:0] o_fv(input int sel);    return sel ? fv1 : fv0;         endfunction
  function automatic logic [31:0] o_first(input int sel); return sel ? first1 : first0;   endfunction
  function automatic logic [31:0] o_din(input int sel);   return sel ? dut_in1 : dut_in0; endfunction

  task automatic set_start(input int sel, input logic v);
    if (sel != 0) start1 = v; else start0 = v;
  endtask

  // One full run: start pulse, per-cycle pattern/hold check, then the final report.
  // repulse_at >= 0 raises start again at that cycle of the run (must be ignored).
  task automatic run(input int sel, input logic [NPAT-1:0] tt, input int repulse_at);
    int settle, runlen, cyc;
    settle = sel ? 3 : 1;
    runlen = NPAT * (settle + 1);
    if (sel != 0) truth1 = tt; else truth0 = tt;
    set_start(sel, 1'b1);
    @(negedge clk);
    set_start(sel, 1'b0);
    cyc = 0;
    // First cycle after the start edge: report cleared, run in progress.
    check("start_clr_err", o_err(sel), 0);
    check("start_clr_fv", o_fv(sel), 0);
    check("start_clr_first", o_first(sel), 0);
    check("start_clr_pass", o_pass(sel), 0);
    while (o_done(sel) == 0) begin
      if (cyc >= runlen + 8) begin
        check("done_timeout", cyc, runlen);
        break;
      end
      if (cyc < runlen) begin
        check("busy_in_run", o_busy(sel), 1);
        check("pattern_hold", o_din(sel), cyc / (settle + 1));
      end
      if (cyc == repulse_at) set_start(sel, 1'b1);
      if (cyc == repulse_at + 1) set_start(sel, 1'b0);
      @(negedge clk);
      cyc++;
    end
    set_start(sel, 1'b0);
    check("done_latency", cyc, runlen);
    check("done_busy", o_busy(sel), 0);
    check("done_dut_in", o_din(sel), NPAT - 1);
    check("err_count", o_err(sel), ref_errs(tt));
    check("fail_valid", o_fv(sel), (ref_errs(tt) != 0) ? 1 : 0);
    check("first_fail", o_first(sel), ref_first(tt));
    check("pass", o_pass(sel), (ref_errs(tt) == 0) ? 1 : 0);
    // Report must hold while idling in DONE.
    repeat (3) @(negedge clk);
    check("done_hold", o_done(sel), 1);
    check("err_hold", o_err(sel), ref_errs(tt));
  endtask

  task automatic check_all_zero(input int sel, input string tag);
    check({tag, "_busy"}, o_busy(sel), 0);
    check({tag, "_done"}, o_done(sel), 0);
    check({tag, "_pass"}, o_pass(sel), 0);
    check({tag, "_err"}, o_err(sel), 0);
    check({tag, "_fv"}, o_fv(sel), 0);
    check({tag, "_first"}, o_first(sel), 0);
    check({tag, "_din"}, o_din(sel), 0);
  endtask

  initial begin
    logic [NPAT-1:0] gold;
    logic [NPAT-1:0] rtt;
    int guard;
    gold   = golden_tt();
    rst    = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    truth0 = '0;
    truth1 = '0;
    repeat (2) @(negedge clk);
    check_all_zero(0, "reset0");
    check_all_zero(1, "reset1");
    rst = 1'b0;
    @(negedge clk);

    // Golden, stuck-at-0, inverted (all mismatch, must not wrap).
    run(0, gold, -1);
    run(0, '0, -1);
    run(0, ~gold, -1);

    // Start re-pulsed mid-run is ignored; restart from DONE reproduces the report.
    run(0, '0, 5);
    run(0, '0, -1);

    // Reset mid-run at pattern 5, with start also high: reset wins, back to IDLE.
    truth0 = gold;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    guard = 0;
    while (dut_in0 != 3'd5 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("reach_pat5", dut_in0, 5);
    rst    = 1'b1;
    start0 = 1'b1;
    @(negedge clk);
    check_all_zero(0, "midrun_rst");
    rst    = 1'b0;
    start0 = 1'b0;
    @(negedge clk);
    check("rst_stays_idle", busy0, 0);
    run(0, gold, -1);

    // Longer settle: each pattern held 4 cycles, done after 32.
    run(1, gold, -1);
    run(1, ~gold, 9);

    // Random truth tables on both instances.
    for (int k = 0; k < 12; k++) begin
      rtt = NPAT'($urandom_range(0, (1 << NPAT) - 1));
      if (k == 0) rtt = EXP_TT ^ 8'h80;  // only the last pattern mismatches
      run(k % 3 == 2 ? 1 : 0, rtt, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
